// File: rtl/sprite_pkg.sv
// sprite_pkg: shared types and constants for the sprite renderer.
//   state_t         frame-pass FSM states
//   ORIENT_*        one-hot player facing codes (anything else means down)
//   *_COLOR         fixed plot colours
//   BMP_*           BMP_H x BMP_W sprite bitmaps, index [row][col]; col 0 is the row's LSB
package sprite_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ERASE,
        ST_DRAW,
        ST_DONE
    } state_t;

    localparam logic [3:0] ORIENT_LEFT  = 4'b1000;
    localparam logic [3:0] ORIENT_RIGHT = 4'b0100;
    localparam logic [3:0] ORIENT_UP    = 4'b0010;

    localparam logic [2:0] PLAYER_COLOR = 3'b100;
    localparam logic [2:0] ERASE_COLOR  = 3'b000;

    localparam int unsigned BMP_W = 5;
    localparam int unsigned BMP_H = 5;

    typedef logic [BMP_W-1:0] bmp_row_t;
    // Ascending row range so the patterns below read row0 first.
    typedef logic [0:BMP_H-1][BMP_W-1:0] bmp_t;

    localparam bmp_t BMP_LEFT  = '{5'b11000, 5'b11100, 5'b10011, 5'b11100, 5'b11000};
    localparam bmp_t BMP_RIGHT = '{5'b00011, 5'b00111, 5'b11001, 5'b00111, 5'b00011};
    localparam bmp_t BMP_UP    = '{5'b00100, 5'b00100, 5'b01010, 5'b11011, 5'b11111};
    localparam bmp_t BMP_DOWN  = '{5'b11111, 5'b11011, 5'b01010, 5'b00100, 5'b00100};
    localparam bmp_t BMP_GHOST = '{5'b10001, 5'b01110, 5'b00100, 5'b01110, 5'b10001};

endpackage

// File: rtl/sprite_bitmap_rom.sv
// sprite_bitmap_rom: combinational sprite bitmap lookup.
//   is_player_i         1 selects a player bitmap by orientation, 0 the ghost bitmap
//   orientation_i       one-hot player facing
//   sx_i, sy_i          column / row within the sprite box
//   pixel_o             bitmap bit at (sx_i, sy_i)
//   player_color_sel_o  1 when the player colour applies, 0 for the ghost colour
module sprite_bitmap_rom
    import sprite_pkg::*;
#(
    parameter int unsigned SX_W = 3,
    parameter int unsigned SY_W = 3
) (
    input  logic            is_player_i,
    input  logic [3:0]      orientation_i,
    input  logic [SX_W-1:0] sx_i,
    input  logic [SY_W-1:0] sy_i,
    output logic            pixel_o,
    output logic            player_color_sel_o
);

    bmp_t     bmp;
    bmp_row_t row;

    always_comb begin
        bmp = BMP_GHOST;
        if (is_player_i) begin
            case (orientation_i)
                ORIENT_LEFT:  bmp = BMP_LEFT;
                ORIENT_RIGHT: bmp = BMP_RIGHT;
                ORIENT_UP:    bmp = BMP_UP;
                default:      bmp = BMP_DOWN;
            endcase
        end
    end

    assign row                = bmp[sy_i];
    assign pixel_o            = row[sx_i];
    assign player_color_sel_o = is_player_i;

endmodule

// File: rtl/sprite_renderer.sv
// sprite_renderer: per-frame erase/redraw of NUM_CHARS sprites onto the VGA plot port.
//   clock_50, reset        clock; synchronous active-high reset
//   start                  one-cycle frame request, ignored while busy
//   maze_orientation       player facing, one-hot
//   char_index             register-file read address (current character)
//   char_x/char_y          position of the indexed character (combinational read)
//   char_active            indexed character is to be drawn
//   char_color             ghost colour (unused for index 0)
//   busy, done             pass in progress / one-cycle end-of-pass pulse
//   vga_plot/x/y/color     registered plot strobe, pixel coordinates and colour
module sprite_renderer
    import sprite_pkg::*;
#(
    parameter int unsigned NUM_CHARS = 8,
    parameter int unsigned SPRITE_W  = 5,
    parameter int unsigned SPRITE_H  = 5,
    parameter int unsigned X_OFFSET  = 26,
    parameter int unsigned Y_OFFSET  = 1
) (
    input  logic                         clock_50,
    input  logic                         reset,
    input  logic                         start,
    input  logic [3:0]                   maze_orientation,
    output logic [$clog2(NUM_CHARS)-1:0] char_index,
    input  logic [7:0]                   char_x,
    input  logic [7:0]                   char_y,
    input  logic                         char_active,
    input  logic [2:0]                   char_color,
    output logic                         busy,
    output logic                         done,
    output logic                         vga_plot,
    output logic [7:0]                   vga_x,
    output logic [7:0]                   vga_y,
    output logic [2:0]                   vga_color
);

    localparam int unsigned IDX_W = $clog2(NUM_CHARS);
    localparam int unsigned SX_W  = $clog2(SPRITE_W);
    localparam int unsigned SY_W  = $clog2(SPRITE_H);

    if (SPRITE_W != BMP_W || SPRITE_H != BMP_H) begin : g_bad_sprite_size
        $error("sprite_renderer: SPRITE_W/SPRITE_H do not match the sprite_pkg bitmaps");
    end

    state_t             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic [SX_W-1:0]    sx_q;
    logic [SY_W-1:0]    sy_q;
    logic [7:0]         prev_x_q [NUM_CHARS];
    logic [7:0]         prev_y_q [NUM_CHARS];
    logic [NUM_CHARS-1:0] prev_valid_q;
    logic               vga_plot_q;
    logic [7:0]         vga_x_q;
    logic [7:0]         vga_y_q;
    logic [2:0]         vga_color_q;

    logic               sx_last, sy_last, idx_last;
    logic               erase_skip, draw_skip, char_done;
    logic               bmp_pixel, player_color_sel;
    logic [7:0]         base_x, base_y;
    logic               plot_d;
    logic [7:0]         x_d, y_d;
    logic [2:0]         color_d;

    sprite_bitmap_rom #(
        .SX_W(SX_W),
        .SY_W(SY_W)
    ) u_rom (
        .is_player_i        (idx_q == '0),
        .orientation_i      (maze_orientation),
        .sx_i               (sx_q),
        .sy_i               (sy_q),
        .pixel_o            (bmp_pixel),
        .player_color_sel_o (player_color_sel)
    );

    assign sx_last    = (sx_q == SX_W'(SPRITE_W - 1));
    assign sy_last    = (sy_q == SY_W'(SPRITE_H - 1));
    assign idx_last   = (idx_q == IDX_W'(NUM_CHARS - 1));
    assign erase_skip = !prev_valid_q[idx_q];
    assign draw_skip  = !char_active;

    // Erase walks the box where the character was last drawn; draw uses the live position.
    assign base_x = (state_q == ST_ERASE) ? prev_x_q[idx_q] : char_x;
    assign base_y = (state_q == ST_ERASE) ? prev_y_q[idx_q] : char_y;
    assign x_d    = base_x + 8'(sx_q) + 8'(X_OFFSET);
    assign y_d    = base_y + 8'(sy_q) + 8'(Y_OFFSET);

    always_comb begin
        plot_d    = 1'b0;
        color_d   = ERASE_COLOR;
        char_done = 1'b0;
        case (state_q)
            ST_ERASE: begin
                plot_d    = !erase_skip;
                char_done = erase_skip || (sx_last && sy_last);
            end
            ST_DRAW: begin
                plot_d    = !draw_skip && bmp_pixel;
                color_d   = player_color_sel ? PLAYER_COLOR : char_color;
                char_done = draw_skip || (sx_last && sy_last);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock_50) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            sx_q         <= '0;
            sy_q         <= '0;
            prev_valid_q <= '0;
            for (int unsigned i = 0; i < NUM_CHARS; i++) begin
                prev_x_q[i] <= '0;
                prev_y_q[i] <= '0;
            end
            vga_plot_q   <= 1'b0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_color_q  <= '0;
        end else begin
            vga_plot_q <= plot_d;
            if (plot_d) begin
                vga_x_q     <= x_d;
                vga_y_q     <= y_d;
                vga_color_q <= color_d;
            end

            unique case (state_q)
                ST_IDLE: begin
                    if (start) state_q <= ST_ERASE;
                end
                ST_ERASE, ST_DRAW: begin
                    if (state_q == ST_DRAW) begin
                        if (draw_skip) begin
                            prev_valid_q[idx_q] <= 1'b0;
                        end else if (sx_q == '0 && sy_q == '0) begin
                            prev_x_q[idx_q]     <= char_x;
                            prev_y_q[idx_q]     <= char_y;
                            prev_valid_q[idx_q] <= 1'b1;
                        end
                    end
                    if (char_done) begin
                        sx_q <= '0;
                        sy_q <= '0;
                        if (idx_last) begin
                            idx_q   <= '0;
                            state_q <= (state_q == ST_ERASE) ? ST_DRAW : ST_DONE;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end else if (sx_last) begin
                        sx_q <= '0;
                        sy_q <= sy_q + 1'b1;
                    end else begin
                        sx_q <= sx_q + 1'b1;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
            endcase
        end
    end

    assign char_index = idx_q;
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign vga_plot   = vga_plot_q;
    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_color  = vga_color_q;

endmodule

// File: tb/tb_sprite_renderer.sv
// tb_sprite_renderer: randomized frame passes checked cycle by cycle against a
// pixel-list reference model built from the sprite rules.
module tb_sprite_renderer;

    logic       clock_50 = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] maze_orientation;
    logic [2:0] char_index;
    logic [7:0] char_x, char_y;
    logic       char_active;
    logic [2:0] char_color;
    logic       busy, done, vga_plot;
    logic [7:0] vga_x, vga_y;
    logic [2:0] vga_color;

    // Character register file seen by the DUT.
    logic [7:0] cx   [8];
    logic [7:0] cy   [8];
    logic       cact [8];
    logic [2:0] ccol [8];

    // Model memory of where each character was last drawn.
    int  mx [8];
    int  my [8];
    bit  mvalid [8];

    typedef struct {
        bit plot;
        int idx;
        int x;
        int y;
        int col;
    } pix_t;

    pix_t expq[$];
    int   n_erase;
    int   n_vectors = 0;
    int   n_miscompares = 0;

    always #10 clock_50 = ~clock_50;

    assign char_x      = cx[char_index];
    assign char_y      = cy[char_index];
    assign char_active = cact[char_index];
    assign char_color  = ccol[char_index];

    sprite_renderer #(
        .NUM_CHARS(8),
        .SPRITE_W (5),
        .SPRITE_H (5),
        .X_OFFSET (26),
        .Y_OFFSET (1)
    ) dut (
        .clock_50         (clock_50),
        .reset            (reset),
        .start            (start),
        .maze_orientation (maze_orientation),
        .char_index       (char_index),
        .char_x           (char_x),
        .char_y           (char_y),
        .char_active      (char_active),
        .char_color       (char_color),
        .busy             (busy),
        .done             (done),
        .vga_plot         (vga_plot),
        .vga_x            (vga_x),
        .vga_y            (vga_y),
        .vga_color        (vga_color)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // kind: 0 left, 1 right, 2 up, 3 down, 4 ghost. Rows written MSB first; col c is bit c.
    function automatic bit bmp_bit(input int kind, input int r, input int c);
        string s [5];
        case (kind)
            0:       s = '{"11000", "11100", "10011", "11100", "11000"};
            1:       s = '{"00011", "00111", "11001", "00111", "00011"};
            2:       s = '{"00100", "00100", "01010", "11011", "11111"};
            3:       s = '{"11111", "11011", "01010", "00100", "00100"};
            default: s = '{"10001", "01110", "00100", "01110", "10001"};
        endcase
        return s[r].getc(4 - c) == "1";
    endfunction

    function automatic int orient_kind(input logic [3:0] o);
        if (o == 4'b1000) return 0;
        if (o == 4'b0100) return 1;
        if (o == 4'b0010) return 2;
        return 3;
    endfunction

    // One entry per DUT cycle of the pass: the plot decision and the index being served.
    task automatic build_model();
        pix_t p;
        expq.delete();
        for (int c = 0; c < 8; c++) begin
            if (mvalid[c]) begin
                for (int r = 0; r < 5; r++)
                    for (int s = 0; s < 5; s++) begin
                        p = '{1'b1, c, (mx[c] + s + 26) % 256, (my[c] + r + 1) % 256, 0};
                        expq.push_back(p);
                    end
            end else begin
                p = '{1'b0, c, 0, 0, 0};
                expq.push_back(p);
            end
        end
        n_erase = expq.size();
        for (int c = 0; c < 8; c++) begin
            if (cact[c]) begin
                for (int r = 0; r < 5; r++)
                    for (int s = 0; s < 5; s++) begin
                        p.plot = bmp_bit(c == 0 ? orient_kind(maze_orientation) : 4, r, s);
                        p.idx  = c;
                        p.x    = (int'(cx[c]) + s + 26) % 256;
                        p.y    = (int'(cy[c]) + r + 1) % 256;
                        p.col  = (c == 0) ? 4 : int'(ccol[c]);
                        expq.push_back(p);
                    end
                mx[c] = cx[c];
                my[c] = cy[c];
                mvalid[c] = 1'b1;
            end else begin
                p = '{1'b0, c, 0, 0, 0};
                expq.push_back(p);
                mvalid[c] = 1'b0;
            end
        end
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_plot"},  vga_plot, 0);
        check_eq({tag, "_busy"},  busy, 0);
        check_eq({tag, "_done"},  done, 0);
        check_eq({tag, "_index"}, char_index, 0);
        check_eq({tag, "_x"},     vga_x, 0);
        check_eq({tag, "_y"},     vga_y, 0);
        check_eq({tag, "_color"}, vga_color, 0);
    endtask

    // Entered at a negedge with the DUT idle. With do_reset, reset is applied mid-DRAW.
    task automatic run_pass(input bit do_reset);
        int total, reset_n, plots_exp, plots_got;
        pix_t e;
        build_model();
        total     = expq.size();
        reset_n   = do_reset ? n_erase + 2 + $urandom_range(0, total - n_erase - 2) : 0;
        plots_exp = 0;
        plots_got = 0;
        start = 1'b1;
        @(negedge clock_50);
        start = 1'b0;
        check_eq("busy_first", busy, 1);
        check_eq("index", char_index, expq[0].idx);
        for (int n = 2; n <= total + 2; n++) begin
            @(negedge clock_50);
            if (n <= total + 1) begin
                e = expq[n - 2];
                check_eq("plot", vga_plot, e.plot);
                if (e.plot) begin
                    plots_exp++;
                    check_eq("pixel_xyc", {vga_x, vga_y, vga_color}, (e.x << 11) | (e.y << 3) | e.col);
                end
                if (vga_plot) plots_got++;
                check_eq("busy", busy, 1);
                check_eq("done", done, (n == total + 1) ? 1 : 0);
                check_eq("index", char_index, (n <= total) ? expq[n - 1].idx : 0);
                if (n == reset_n) begin
                    reset = 1'b1;
                    @(negedge clock_50);
                    reset = 1'b0;
                    check_reset_state("mid_reset");
                    for (int c = 0; c < 8; c++) mvalid[c] = 1'b0;
                    return;
                end
                // A request during DONE must be dropped.
                if (n == total + 1) start = 1'b1;
            end else begin
                start = 1'b0;
                check_eq("busy_after", busy, 0);
                check_eq("done_after", done, 0);
                check_eq("plot_after", vga_plot, 0);
            end
        end
        check_eq("plot_count", plots_got, plots_exp);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        maze_orientation = 4'b0001;
        for (int c = 0; c < 8; c++) begin
            cx[c] = 8'($urandom_range(0, 200));
            cy[c] = 8'($urandom_range(0, 200));
            cact[c] = 1'b1;
            ccol[c] = 3'b001;
            mvalid[c] = 1'b0;
            mx[c] = 0;
            my[c] = 0;
        end
        repeat (3) @(negedge clock_50);
        check_reset_state("reset");
        reset = 1'b0;

        // All active, player facing down, ghosts colour 001.
        run_pass(1'b0);

        // Everyone moves; player at origin facing left.
        for (int c = 1; c < 8; c++) begin
            cx[c] = 8'($urandom);
            cy[c] = 8'($urandom);
        end
        cx[0] = 8'd0;
        cy[0] = 8'd0;
        maze_orientation = 4'b1000;
        run_pass(1'b0);

        // Character 3 inactive, character 5 near the right wrap boundary.
        cact[3] = 1'b0;
        cx[5] = 8'd250;
        maze_orientation = 4'b0100;
        run_pass(1'b0);

        // Character 3 back; its erase is skipped this pass.
        cact[3] = 1'b1;
        maze_orientation = 4'b0010;
        run_pass(1'b0);

        // Reset in the middle of DRAW, then a pass whose erase is all skips.
        run_pass(1'b1);
        run_pass(1'b0);

        // Random passes: activity, positions, colours and orientation (incl. non one-hot).
        for (int k = 0; k < 6; k++) begin
            for (int c = 0; c < 8; c++) begin
                cx[c]   = 8'($urandom);
                cy[c]   = 8'($urandom);
                cact[c] = 1'($urandom_range(0, 3) != 0);
                ccol[c] = 3'($urandom);
            end
            maze_orientation = 4'($urandom);
            run_pass(k == 3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
